// File: rtl/contador_pkg.sv
// contador_pkg: shared definitions for the BCD countdown timer.
//   - state_t   : timer FSM states (IDLE, RUN, PAUSE, DONE)
//   - BCD_W     : width of one BCD digit
//   - digit_mod : modulus of a digit position (6 for odd positions in mm:ss
//                 mode, 10 otherwise)
package contador_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Odd digit positions count tens of seconds/minutes in sexagesimal mode.
  function automatic int digit_mod(input int index, input int sexagesimal);
    if ((sexagesimal != 0) && ((index % 2) == 1)) begin
      return 6;
    end else begin
      return 10;
    end
  endfunction

endpackage

// File: rtl/contador_regressivo_bcd_digito.sv
// digito_regressivo: one BCD down-counting digit with configurable modulus.
// Ports:
//   clock      : system clock, rising edge
//   rst        : asynchronous active-low reset (q -> 0)
//   load       : load load_d into the digit
//   load_d     : BCD value to load
//   clr        : synchronous clear to 0 (dominates load and dec)
//   dec        : decrement this digit (wraps 0 -> MOD-1)
//   q          : current digit value
//   borrow_out : dec while q==0, i.e. the next digit must decrement too
//   range_err  : load_d is not a legal value for this digit (>= MOD)
module digito_regressivo
  import contador_pkg::*;
#(
  parameter int MOD = 10
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [BCD_W-1:0] load_d,
  input  logic             clr,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             borrow_out,
  output logic             range_err
);

  localparam logic [BCD_W-1:0] MOD_V  = BCD_W'(MOD);
  localparam logic [BCD_W-1:0] MAX_V  = BCD_W'(MOD - 1);
  localparam logic [BCD_W-1:0] ZERO_V = {BCD_W{1'b0}};
  localparam logic [BCD_W-1:0] ONE_V  = BCD_W'(1);

  logic [BCD_W-1:0] q_r;

  // Digit register: clear > load > decrement > hold.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      q_r <= ZERO_V;
    end else if (clr) begin
      q_r <= ZERO_V;
    end else if (load) begin
      q_r <= load_d;
    end else if (dec) begin
      if (q_r == ZERO_V) begin
        q_r <= MAX_V;
      end else begin
        q_r <= q_r - ONE_V;
      end
    end else begin
      q_r <= q_r;
    end
  end

  assign q          = q_r;
  assign borrow_out = dec & (q_r == ZERO_V);
  assign range_err  = (load_d >= MOD_V);

endmodule

// File: rtl/contador_regressivo_bcd.sv
// contador_regressivo_bcd: multi-digit BCD countdown timer (mm:ss style when
// SEXAGESIMAL=1). Counts down on each tick while running, pulses done on
// reaching zero.
// Optional feature macro: CONTADOR_AUTO_RELOAD_EN -- when defined, reaching
// zero in RUN reloads the latched preset and keeps running.
// Ports:
//   clock    : system clock, rising edge
//   rst      : asynchronous active-low reset
//   tick     : one-cycle count-enable strobe
//   start    : load preset and run (IDLE/DONE) or resume (PAUSE)
//   pause    : freeze count while running
//   stop     : abort to IDLE, clear count (highest priority)
//   load_val : BCD preset, sampled on an accepted start from IDLE/DONE
//   count    : current BCD value
//   running  : state is RUN
//   zero     : count is all zeros
//   done     : one-cycle pulse when the count reaches zero
//   load_err : one-cycle pulse when a preset is rejected
module contador_regressivo_bcd
  import contador_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SEXAGESIMAL = 1
) (
  input  logic                        clock,
  input  logic                        rst,
  input  logic                        tick,
  input  logic                        start,
  input  logic                        pause,
  input  logic                        stop,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic                        running,
  output logic                        zero,
  output logic                        done,
  output logic                        load_err
);

  localparam int CW = BCD_W * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   preset_r;
  logic [CW-1:0]   count_s;
  logic [CW-1:0]   load_d_s;
  logic [NUM_DIGITS-1:0] dig_err_s;
  logic [NUM_DIGITS-1:0] dig_dec_s;
  logic [NUM_DIGITS-1:0] dig_borrow_s;

  logic            preset_err_s;
  logic            preset_zero_s;
  logic            terminal_s;
  logic            underflow_s;
  logic            load_s;
  logic            reload_s;
  logic            clr_s;
  logic            dig_clr_s;
  logic            dec_en_s;
  logic            latch_s;
  logic            done_nxt_s;
  logic            err_nxt_s;
  logic            zero_nxt_s;

  logic            running_r;
  logic            zero_r;
  logic            done_r;
  logic            load_err_r;

  assign preset_err_s  = |dig_err_s;
  assign preset_zero_s = (load_val == CNT_ZERO);
  // The next decrement lands on zero exactly when the count is 1.
  assign terminal_s    = (count_s == CNT_ONE);
  // Reload uses the latched preset; everything else loads the live preset.
  assign load_d_s      = reload_s ? preset_r : load_val;

  // A borrow out of the top digit means a decrement from zero, which the FSM
  // never issues; clear instead of wrapping to the maximum value.
  assign underflow_s   = dig_borrow_s[NUM_DIGITS-1];
  assign dig_clr_s     = clr_s | underflow_s;

  // Digit cascade: each digit decrements when all lower digits borrow.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_first
      assign dig_dec_s[k] = dec_en_s;
    end else begin : g_rest
      assign dig_dec_s[k] = dig_borrow_s[k-1];
    end

    digito_regressivo #(
      .MOD(digit_mod(k, SEXAGESIMAL))
    ) u_digito (
      .clock      (clock),
      .rst        (rst),
      .load       (load_s),
      .load_d     (load_d_s[k*BCD_W +: BCD_W]),
      .clr        (dig_clr_s),
      .dec        (dig_dec_s[k]),
      .q          (count_s[k*BCD_W +: BCD_W]),
      .borrow_out (dig_borrow_s[k]),
      .range_err  (dig_err_s[k])
    );
  end

  // Next-state and control decode; priority stop > start > pause > tick.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    reload_s    = 1'b0;
    clr_s       = 1'b0;
    dec_en_s    = 1'b0;
    latch_s     = 1'b0;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    zero_nxt_s  = zero_r;

    if (stop) begin
      state_nxt_s = IDLE;
      clr_s       = 1'b1;
      zero_nxt_s  = 1'b1;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            if (preset_err_s) begin
              err_nxt_s = 1'b1;
            end else if (preset_zero_s) begin
              clr_s       = 1'b1;
              done_nxt_s  = 1'b1;
              zero_nxt_s  = 1'b1;
              state_nxt_s = DONE;
            end else begin
              load_s      = 1'b1;
              latch_s     = 1'b1;
              zero_nxt_s  = 1'b0;
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = state_r;
          end
        end
        RUN: begin
          if (pause) begin
            state_nxt_s = PAUSE;
          end else if (tick) begin
            if (terminal_s) begin
              done_nxt_s = 1'b1;
`ifdef CONTADOR_AUTO_RELOAD_EN
              reload_s   = 1'b1;
              load_s     = 1'b1;
              zero_nxt_s = 1'b0;
`else
              dec_en_s    = 1'b1;
              zero_nxt_s  = 1'b1;
              state_nxt_s = DONE;
`endif
            end else begin
              dec_en_s   = 1'b1;
              zero_nxt_s = 1'b0;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        PAUSE: begin
          if (start) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = PAUSE;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          clr_s       = 1'b1;
          zero_nxt_s  = 1'b1;
        end
      endcase
    end
  end

  // State, preset latch and registered status outputs.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      preset_r   <= CNT_ZERO;
      running_r  <= 1'b0;
      zero_r     <= 1'b1;
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      preset_r   <= latch_s ? load_val : preset_r;
      running_r  <= (state_nxt_s == RUN);
      zero_r     <= zero_nxt_s;
      done_r     <= done_nxt_s;
      load_err_r <= err_nxt_s;
    end
  end

  assign count    = count_s;
  assign running  = running_r;
  assign zero     = zero_r;
  assign done     = done_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_contador_regressivo_bcd.sv
// tb_contador_regressivo_bcd: scoreboard bench for the BCD countdown timer.
// Two instances share the stimulus: mm:ss digits and all-decimal digits.
// A reference model works on the integer value of the count.
module tb_contador_regressivo_bcd;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  typedef struct {
    int          st;
    logic [15:0] cnt;
    logic [15:0] pre;
    logic        done;
    logic        err;
  } mdl_t;

  typedef struct {
    logic [15:0] cnt;
    logic        running;
    logic        zero;
    logic        done;
    logic        err;
    logic [15:0] cnt10;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        tick  = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop  = 1'b0;
  logic [15:0] load_val = 16'h0000;

  logic [15:0] count, count10;
  logic        running, zero, done, load_err;
  logic        running10, zero10, done10, load_err10;

  int checks   = 0;
  int failures = 0;

  mdl_t m6, m10;
  exp_t sb[$];

  contador_regressivo_bcd #(.NUM_DIGITS(4), .SEXAGESIMAL(1)) dut (
    .clock(clock), .rst(rst), .tick(tick), .start(start), .pause(pause),
    .stop(stop), .load_val(load_val), .count(count), .running(running),
    .zero(zero), .done(done), .load_err(load_err)
  );

  contador_regressivo_bcd #(.NUM_DIGITS(4), .SEXAGESIMAL(0)) dut10 (
    .clock(clock), .rst(rst), .tick(tick), .start(start), .pause(pause),
    .stop(stop), .load_val(load_val), .count(count10), .running(running10),
    .zero(zero10), .done(done10), .load_err(load_err10)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dmod(input int i, input int sex);
    return ((sex != 0) && (i % 2 == 1)) ? 6 : 10;
  endfunction

  function automatic int to_int(input logic [15:0] c, input int sex);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      v += int'(c[4*i +: 4]) * w;
      w *= dmod(i, sex);
    end
    return v;
  endfunction

  function automatic logic [15:0] from_int(input int v, input int sex);
    logic [15:0] c = 16'h0000;
    int d;
    for (int i = 0; i < 4; i++) begin
      d = v % dmod(i, sex);
      c[4*i +: 4] = d[3:0];
      v = v / dmod(i, sex);
    end
    return c;
  endfunction

  function automatic logic valid_bcd(input logic [15:0] c, input int sex);
    for (int i = 0; i < 4; i++) begin
      if (int'(c[4*i +: 4]) >= dmod(i, sex)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int sex, input logic tk,
                                 input logic sa, input logic pa, input logic sp,
                                 input logic [15:0] lv);
    mdl_t n = m;
    int   v;
    n.done = 1'b0;
    n.err  = 1'b0;
    if (sp) begin
      n.st  = S_IDLE;
      n.cnt = 16'h0000;
    end else if (m.st == S_IDLE || m.st == S_DONE) begin
      if (sa) begin
        if (!valid_bcd(lv, sex)) begin
          n.err = 1'b1;
        end else if (lv == 16'h0000) begin
          n.cnt = 16'h0000; n.done = 1'b1; n.st = S_DONE;
        end else begin
          n.cnt = lv; n.pre = lv; n.st = S_RUN;
        end
      end
    end else if (m.st == S_RUN) begin
      if (pa) begin
        n.st = S_PAUSE;
      end else if (tk) begin
        v = to_int(m.cnt, sex) - 1;
        if (v == 0) begin
          n.done = 1'b1;
`ifdef CONTADOR_AUTO_RELOAD_EN
          n.cnt = m.pre;
`else
          n.cnt = 16'h0000; n.st = S_DONE;
`endif
        end else begin
          n.cnt = from_int(v, sex);
        end
      end
    end else if (m.st == S_PAUSE) begin
      if (sa) n.st = S_RUN;
    end
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = S_IDLE; r.cnt = 16'h0000; r.pre = 16'h0000; r.done = 1'b0; r.err = 1'b0;
    return r;
  endfunction

  task automatic step(input logic tk, input logic sa, input logic pa,
                      input logic sp, input logic [15:0] lv);
    exp_t e;
    @(negedge clock);
    tick = tk; start = sa; pause = pa; stop = sp; load_val = lv;
    m6  = mstep(m6, 1, tk, sa, pa, sp, lv);
    m10 = mstep(m10, 0, tk, sa, pa, sp, lv);
    e.cnt = m6.cnt; e.running = (m6.st == S_RUN); e.zero = (m6.cnt == 16'h0000);
    e.done = m6.done; e.err = m6.err; e.cnt10 = m10.cnt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    tick = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    e = sb.pop_front();
    check_eq("count",    32'(count),    32'(e.cnt));
    check_eq("running",  32'(running),  32'(e.running));
    check_eq("zero",     32'(zero),     32'(e.zero));
    check_eq("done",     32'(done),     32'(e.done));
    check_eq("load_err", 32'(load_err), 32'(e.err));
    check_eq("count10",  32'(count10),  32'(e.cnt10));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic do_start(input logic [15:0] lv);
    step(1'b0, 1'b1, 1'b0, 1'b0, lv);
  endtask

  task automatic do_stop();
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
  endtask

  initial begin
    logic [15:0] presets [6];
    int          r;
    presets = '{16'h0003, 16'h0100, 16'h0070, 16'h0000, 16'h0959, 16'h0012};

    m6  = mreset();
    m10 = mreset();
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_count",   32'(count),   32'h0);
    check_eq("rst_zero",    32'(zero),    32'h1);
    check_eq("rst_running", 32'(running), 32'h0);
    check_eq("rst_done",    32'(done),    32'h0);
    @(negedge clock);
    rst = 1'b1;

    // Borrow chain across digits.
    do_start(16'h0100);
    ticks(1);
    do_stop();

    // Full run to zero, then one idle cycle so the done pulse width is seen.
    do_start(16'h0003);
    ticks(3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Invalid preset in mm:ss mode (legal for the decimal instance).
    do_start(16'h0070);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_stop();

    // Pause has priority over tick; ticks ignored while paused.
    do_start(16'h0011);
    ticks(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000);
    ticks(5);
    do_start(16'h0000);
    ticks(1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'h0011);

    // Zero preset finishes immediately.
    do_start(16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    do_stop();

    // Reload behaviour (or stop in DONE) with back-to-back ticks.
    do_start(16'h0002);
    ticks(4);
    do_stop();

    // Asynchronous reset mid-run.
    do_start(16'h0343);
    ticks(1);
    @(negedge clock);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_count",   32'(count),   32'h0);
    check_eq("mid_rst_zero",    32'(zero),    32'h1);
    check_eq("mid_rst_running", 32'(running), 32'h0);
    check_eq("mid_rst_done",    32'(done),    32'h0);
    @(posedge clock);
    #1;
    check_eq("mid_rst_done_hold", 32'(done), 32'h0);
    m6  = mreset();
    m10 = mreset();
    @(negedge clock);
    rst = 1'b1;

    // Random control mix.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      step(1'($urandom_range(0, 1)), (r < 8), (r >= 8 && r < 12), (r >= 96),
           presets[$urandom_range(0, 5)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_regressivo_bcd.md
# contador_regressivo_bcd

- Parametrised multi-digit BCD countdown timer for the irrigation controller. Generalises the single tens-of-seconds digit into a full mm:ss (or wider) timer.
- Features: programmable preset, start/pause/stop control, per-digit modulus (6 or 10), range checking of the preset, one-cycle completion pulse.
- Sits between the 1 Hz tick generator and the valve-control FSM, which starts a watering interval and waits for `done`.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of BCD digits; digit 0 is least significant.
- `SEXAGESIMAL`, 1: 1 makes every odd-index digit modulo 6 (mm:ss style); 0 makes all digits modulo 10.

Ports:
- `clock` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `tick` in 1: one-cycle count-enable strobe (1 Hz).
- `start` in 1: load preset and run from IDLE/DONE; resume from PAUSE.
- `pause` in 1: freeze count while RUN.
- `stop` in 1: abort to IDLE and clear count.
- `load_val` in 4*NUM_DIGITS: BCD preset, sampled on accepted `start` from IDLE/DONE.
- `count` out 4*NUM_DIGITS: current BCD value.
- `running` out 1: high in RUN.
- `zero` out 1: high when `count` is all zeros.
- `done` out 1: one-cycle pulse on reaching zero.
- `load_err` out 1: one-cycle pulse when a preset is rejected.

## Operation
- FSM states: IDLE, RUN, PAUSE, DONE.
- Control priority per cycle: `stop` > `start` > `pause` > `tick`.
- Any state, `stop`:
  - go to IDLE, `count`=0.
  - Same-cycle `tick`, `start` and `pause` are discarded.
- IDLE or DONE, `start`, preset valid and nonzero:
  - `count`=`load_val`; preset latched internally; go to RUN.
- IDLE or DONE, `start`, preset valid and all zero:
  - `count`=0; `done` pulses; go to DONE.
- IDLE or DONE, `start`, preset invalid (any digit ≥ its modulus):
  - `load_err` pulses; state and `count` unchanged.
- RUN, `tick` → decrement the cascade:
  - Digit 0 decrements.
  - A digit at 0 with an incoming borrow wraps to modulus−1 and borrows from the next digit.
  - Example: 01:00 → 00:59.
- RUN, terminal decrement (count goes to 0):
  - go to DONE; `done` pulses.
- RUN, `pause`:
  - go to PAUSE; a `tick` in the same cycle is discarded.
- PAUSE:
  - `tick` is ignored.
  - `start` resumes to RUN without reloading.
  - `pause` has no effect.
- DONE:
  - `count` holds 0 until `start` or `stop`.
- Redundant controls (`pause` in IDLE/DONE, `start` in RUN) are ignored.
- `running` = (state==RUN). `zero` is decoded from the `count` register.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Reset values: state IDLE, `count`=0, preset latch=0, `running`=0, `zero`=1, `done`=0, `load_err`=0.
- `count` updates on the clock edge that samples the accepted `tick`/`start`/`stop`, i.e. one cycle of latency.
- `done` rises on the same edge on which `count` becomes 0, and lasts exactly one cycle.
- `load_err` rises on the edge that samples the rejected `start`, and lasts one cycle.
- Back-to-back ticks on consecutive cycles each decrement; there is no minimum tick spacing.
- Reset mid-run: immediate return to reset values; no `done` is generated.

## Configuration
- Macro: `CONTADOR_AUTO_RELOAD_EN`.
- Defined:
  - A terminal decrement in RUN reloads `count` from the latched preset and stays in RUN.
  - `done` still pulses each period.
  - `zero` never asserts during RUN.
  - A zero preset is still handled as "done immediately, enter DONE".
- Undefined: behaviour as in Operation (stop in DONE).

## Structure
- Shared package `contador_pkg`:
  - state enum (IDLE, RUN, PAUSE, DONE);
  - `BCD_W`=4;
  - modulus function `digit_mod(index, SEXAGESIMAL)`.
- One sub-module, `digito_regressivo`, instantiated NUM_DIGITS times by generate:
  - parameter `MOD`;
  - inputs: `clock`, `rst`, `load`, `load_d`, `clr`, `dec`;
  - outputs: `q`, `borrow_out` (= `dec` & `q`==0), `range_err` (= `load_d` ≥ MOD).
- The digit enables chain: `dec` of digit k = RUN & `tick` & all lower borrows.

## Test plan
- Reset:
  - Assert `rst`=0 mid-run at `count`=0x0342.
  - → `count`=0, `zero`=1, `running`=0, no `done` pulse.
- Borrow chain:
  - Preset 0x0100, start, one tick.
  - → `count`=0x0059.
  - With SEXAGESIMAL=0 the same stimulus gives 0x0099.
- Full run:
  - Preset 0x0003, start, 3 ticks.
  - → `count` goes 0x0002, 0x0001, 0x0000.
  - → `done` high for exactly one cycle on the third tick edge; state DONE; `zero`=1.
- Invalid preset:
  - Preset 0x0070 (digit 1 = 7 ≥ 6), start.
  - → `load_err` one-cycle pulse; `count` unchanged; `running`=0.
- Pause/priority:
  - At 0x0010, assert `pause` and `tick` together.
  - → 0x0010 held in PAUSE; 5 further ticks have no effect.
  - `start` → RUN; next tick gives 0x0009.
  - `stop` with `start` in the same cycle → IDLE, `count`=0.
- Auto-reload (macro defined):
  - Preset 0x0002, start, 4 ticks.
  - → `count` sequence 1, 2, 1, 2; `done` pulses on ticks 2 and 4; `running` stays 1.
